apb2mem_bridge: RTL and testbench

APB3 slave front-end for the generated register files. It converts APB transfers into the single-cycle `mem_*` strobe interface that a `*_regf` block consumes, and sits directly upstream of that block. It registers every request, issues exactly one `mem_ena` cycle per accepted transfer, and captures `mem_rdata`/`mem_err` into APB `prdata`/`pslverr`.

---
 rtl/apb2mem_bridge.sv | 130 +++++++++++++
 tb/tb_apb2mem_bridge.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/apb2mem_bridge.sv
// rtl/apb2mem_bridge.sv - APB3 slave to single-cycle mem_* strobe bridge for *_regf blocks
// Optional write-strobe rejection via APB2MEM_STRB_CHECK_EN.
module apb2mem_bridge #(
  parameter int ADDR_WIDTH = 13
) (
  input  logic                  main_clk_i,
  input  logic                  main_rst_an_i,
  input  logic                  apb_psel_i,
  input  logic                  apb_penable_i,
  input  logic [ADDR_WIDTH+1:0] apb_paddr_i,
  input  logic                  apb_pwrite_i,
  input  logic [31:0]           apb_pwdata_i,
  input  logic [3:0]            apb_pstrb_i,
  output logic [31:0]           apb_prdata_o,
  output logic                  apb_pready_o,
  output logic                  apb_pslverr_o,
  output logic                  mem_ena_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_wena_o,
  output logic [31:0]           mem_wdata_o,
  input  logic [31:0]           mem_rdata_i,
  input  logic                  mem_err_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  wena_q, wena_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  reject_q, reject_d;
  logic                  ena_q, ena_d;
  logic                  pready_q, pready_d;
  logic [31:0]           prdata_q, prdata_d;
  logic                  pslverr_q, pslverr_d;
  logic                  strb_bad;

`ifdef APB2MEM_STRB_CHECK_EN
  // Partial writes are not supported by the regf, so refuse them up front.
  assign strb_bad = apb_pwrite_i & (apb_pstrb_i != 4'hF);
`else
  logic unused_pstrb;
  assign unused_pstrb = ^apb_pstrb_i;
  assign strb_bad     = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wena_d    = wena_q;
    wdata_d   = wdata_q;
    reject_d  = reject_q;
    ena_d     = ena_q;
    pready_d  = pready_q;
    prdata_d  = prdata_q;
    pslverr_d = pslverr_q;
    case (state_q)
      IDLE: begin
        if (apb_psel_i) begin
          addr_d   = apb_paddr_i[ADDR_WIDTH+1:2];
          wena_d   = apb_pwrite_i;
          wdata_d  = apb_pwdata_i;
          reject_d = (apb_paddr_i[1:0] != 2'b00) | strb_bad;
          ena_d    = ~reject_d;
          state_d  = ACC;
        end
      end
      ACC: begin
        // Regf response is combinational and only valid during this single cycle.
        ena_d     = 1'b0;
        prdata_d  = (~wena_q & ~reject_q & ~mem_err_i) ? mem_rdata_i : 32'h0;
        pslverr_d = reject_q | mem_err_i;
        pready_d  = 1'b1;
        state_d   = DONE;
      end
      DONE: begin
        if (~apb_psel_i | apb_penable_i) begin
          pready_d  = 1'b0;
          prdata_d  = 32'h0;
          pslverr_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: begin
        ena_d     = 1'b0;
        pready_d  = 1'b0;
        prdata_d  = 32'h0;
        pslverr_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
    if (!main_rst_an_i) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wena_q    <= 1'b0;
      wdata_q   <= 32'h0;
      reject_q  <= 1'b0;
      ena_q     <= 1'b0;
      pready_q  <= 1'b0;
      prdata_q  <= 32'h0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wena_q    <= wena_d;
      wdata_q   <= wdata_d;
      reject_q  <= reject_d;
      ena_q     <= ena_d;
      pready_q  <= pready_d;
      prdata_q  <= prdata_d;
      pslverr_q <= pslverr_d;
    end
  end

  assign apb_prdata_o  = prdata_q;
  assign apb_pready_o  = pready_q;
  assign apb_pslverr_o = pslverr_q;
  assign mem_ena_o     = ena_q;
  assign mem_addr_o    = addr_q;
  assign mem_wena_o    = wena_q;
  assign mem_wdata_o   = wdata_q;

endmodule

// File: tb/tb_apb2mem_bridge.sv
// tb/tb_apb2mem_bridge.sv - directed bench for apb2mem_bridge with a one-register regf stub
module tb_apb2mem_bridge;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic [14:0] paddr = '0;
  logic        pwrite = 1'b0;
  logic [31:0] pwdata = '0;
  logic [3:0]  pstrb = 4'hF;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic        mem_ena;
  logic [12:0] mem_addr;
  logic        mem_wena;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_err;

  logic ctrl_q;
  logic busy = 1'b1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ena_cnt = 0;
  int ena_cyc_last = -100;
  int ena_cyc_prev = -100;
  int b2b_viol = 0;
  logic prev_ena = 1'b0;

  always #5 clk = ~clk;

  apb2mem_bridge #(.ADDR_WIDTH(13)) dut (
    .main_clk_i    (clk),
    .main_rst_an_i (rstn),
    .apb_psel_i    (psel),
    .apb_penable_i (penable),
    .apb_paddr_i   (paddr),
    .apb_pwrite_i  (pwrite),
    .apb_pwdata_i  (pwdata),
    .apb_pstrb_i   (pstrb),
    .apb_prdata_o  (prdata),
    .apb_pready_o  (pready),
    .apb_pslverr_o (pslverr),
    .mem_ena_o     (mem_ena),
    .mem_addr_o    (mem_addr),
    .mem_wena_o    (mem_wena),
    .mem_wdata_o   (mem_wdata),
    .mem_rdata_i   (mem_rdata),
    .mem_err_i     (mem_err)
  );

  // Regf stub: word 0 holds ctrl at bit 0 and the busy status at bit 4; other words decode-error.
  assign mem_rdata = (mem_addr == 13'd0) ? {27'h0, busy, 3'b000, ctrl_q} : 32'h0;
  assign mem_err   = (mem_addr != 13'd0);

  always @(posedge clk or negedge rstn) begin
    if (!rstn) ctrl_q <= 1'b0;
    else if (mem_ena && mem_wena && mem_addr == 13'd0) ctrl_q <= mem_wdata[0];
  end

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (mem_ena) begin
      if (prev_ena) b2b_viol = b2b_viol + 1;
      ena_cnt = ena_cnt + 1;
      ena_cyc_prev = ena_cyc_last;
      ena_cyc_last = cyc;
    end
    prev_ena = mem_ena;
  end

  // Drives one full APB transfer from a negedge and returns on the negedge of cycle T+3.
  task automatic xfer(input logic [14:0] a, input logic w, input logic [31:0] wd, input logic [3:0] st,
                      output logic acc_ena, output logic acc_wena, output logic [12:0] acc_addr,
                      output logic acc_pready, output logic done_pready,
                      output logic [31:0] rd, output logic err);
    psel = 1'b1; penable = 1'b0; paddr = a; pwrite = w; pwdata = wd; pstrb = st;
    @(posedge clk); @(negedge clk);
    acc_ena = mem_ena; acc_wena = mem_wena; acc_addr = mem_addr; acc_pready = pready;
    penable = 1'b1;
    @(posedge clk); @(negedge clk);
    done_pready = pready; rd = prdata; err = pslverr;
    @(posedge clk); @(negedge clk);
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if ({mem_ena, pready, pslverr, mem_wena} !== 4'b0) begin failures++; $display("FAIL reset_ctl got=%b exp=0000", {mem_ena, pready, pslverr, mem_wena}); end
    checks++; if (prdata !== 32'h0) begin failures++; $display("FAIL reset_prdata got=%h exp=0", prdata); end
    checks++; if ({mem_addr, mem_wdata} !== 45'h0) begin failures++; $display("FAIL reset_req got=%h/%h exp=0", mem_addr, mem_wdata); end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    logic e, we, ap, dp, er; logic [12:0] ad; logic [31:0] rd; int n0;
    n0 = ena_cnt;
    xfer(15'h000, 1'b1, 32'h1, 4'hF, e, we, ad, ap, dp, rd, er);
    checks++; if ({e, we, ad} !== {1'b1, 1'b1, 13'd0}) begin failures++; $display("FAIL wr_acc got=%b%b%h exp=11 0", e, we, ad); end
    checks++; if ({ap, dp} !== 2'b01) begin failures++; $display("FAIL wr_pready got=%b%b exp=01", ap, dp); end
    checks++; if (er !== 1'b0) begin failures++; $display("FAIL wr_pslverr got=%b exp=0", er); end
    checks++; if (ena_cnt - n0 !== 1) begin failures++; $display("FAIL wr_ena_count got=%0d exp=1", ena_cnt - n0); end
    checks++; if (pready !== 1'b0) begin failures++; $display("FAIL wr_pready_after got=%b exp=0", pready); end
    xfer(15'h000, 1'b0, 32'h0, 4'hF, e, we, ad, ap, dp, rd, er);
    checks++; if ({rd, er} !== {32'h11, 1'b0}) begin failures++; $display("FAIL rd_back got=%h/%b exp=00000011/0", rd, er); end
    checks++; if ({e, we} !== 2'b10) begin failures++; $display("FAIL rd_acc got=%b%b exp=10", e, we); end
  endtask

  task automatic test_decode_error();
    logic e, we, ap, dp, er; logic [12:0] ad; logic [31:0] rd;
    xfer(15'h004, 1'b0, 32'h0, 4'hF, e, we, ad, ap, dp, rd, er);
    checks++; if ({e, ad} !== {1'b1, 13'd1}) begin failures++; $display("FAIL dec_acc got=%b/%h exp=1/1", e, ad); end
    checks++; if ({rd, er} !== {32'h0, 1'b1}) begin failures++; $display("FAIL dec_resp got=%h/%b exp=0/1", rd, er); end
  endtask

  task automatic test_misaligned();
    logic e, we, ap, dp, er; logic [12:0] ad; logic [31:0] rd; int n0;
    n0 = ena_cnt;
    xfer(15'h002, 1'b1, 32'h0, 4'hF, e, we, ad, ap, dp, rd, er);
    checks++; if (ena_cnt - n0 !== 0) begin failures++; $display("FAIL mis_ena got=%0d exp=0", ena_cnt - n0); end
    checks++; if ({dp, er} !== 2'b11) begin failures++; $display("FAIL mis_resp got=%b%b exp=11", dp, er); end
    xfer(15'h000, 1'b0, 32'h0, 4'hF, e, we, ad, ap, dp, rd, er);
    checks++; if (rd !== 32'h11) begin failures++; $display("FAIL mis_unchanged got=%h exp=00000011", rd); end
  endtask

  task automatic test_strobe();
    logic e, we, ap, dp, er; logic [12:0] ad; logic [31:0] rd; logic exp_err; logic [31:0] exp_rd;
`ifdef APB2MEM_STRB_CHECK_EN
    exp_err = 1'b1; exp_rd = 32'h11;
`else
    exp_err = 1'b0; exp_rd = 32'h10;
`endif
    xfer(15'h000, 1'b1, 32'h0, 4'h1, e, we, ad, ap, dp, rd, er);
    checks++; if (er !== exp_err) begin failures++; $display("FAIL strb_err got=%b exp=%b", er, exp_err); end
    checks++; if (e !== ~exp_err) begin failures++; $display("FAIL strb_ena got=%b exp=%b", e, ~exp_err); end
    xfer(15'h000, 1'b0, 32'h0, 4'h1, e, we, ad, ap, dp, rd, er);
    checks++; if ({rd, er} !== {exp_rd, 1'b0}) begin failures++; $display("FAIL strb_rd got=%h/%b exp=%h/0", rd, er, exp_rd); end
    xfer(15'h000, 1'b1, 32'h1, 4'hF, e, we, ad, ap, dp, rd, er);
  endtask

  task automatic test_back_to_back();
    logic e, we, ap, dp, er; logic [12:0] ad; logic [31:0] rd, rd2; int v0;
    v0 = b2b_viol;
    xfer(15'h000, 1'b0, 32'h0, 4'hF, e, we, ad, ap, dp, rd, er);
    xfer(15'h000, 1'b0, 32'h0, 4'hF, e, we, ad, ap, dp, rd2, er);
    checks++; if (ena_cyc_last - ena_cyc_prev !== 3) begin failures++; $display("FAIL b2b_spacing got=%0d exp=3", ena_cyc_last - ena_cyc_prev); end
    checks++; if (b2b_viol - v0 !== 0) begin failures++; $display("FAIL b2b_consecutive got=%0d exp=0", b2b_viol - v0); end
    checks++; if ({rd, rd2} !== {32'h11, 32'h11}) begin failures++; $display("FAIL b2b_data got=%h/%h exp=00000011/00000011", rd, rd2); end
  endtask

  task automatic test_abandon();
    psel = 1'b1; penable = 1'b0; paddr = 15'h000; pwrite = 1'b0;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    checks++; if ({pready, prdata} !== {1'b1, 32'h11}) begin failures++; $display("FAIL ab_done got=%b/%h exp=1/00000011", pready, prdata); end
    @(posedge clk); @(negedge clk);
    checks++; if (pready !== 1'b1) begin failures++; $display("FAIL ab_hold got=%b exp=1", pready); end
    psel = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++; if ({pready, prdata, mem_ena} !== 34'h0) begin failures++; $display("FAIL ab_idle got=%b/%h/%b exp=0/0/0", pready, prdata, mem_ena); end
    @(posedge clk); @(negedge clk);
    checks++; if (mem_ena !== 1'b0) begin failures++; $display("FAIL ab_noaccess got=%b exp=0", mem_ena); end
  endtask

  task automatic test_reset_mid();
    logic e, we, ap, dp, er; logic [12:0] ad; logic [31:0] rd;
    psel = 1'b1; penable = 1'b0; paddr = 15'h000; pwrite = 1'b1; pwdata = 32'h0; pstrb = 4'hF;
    @(posedge clk); @(negedge clk);
    checks++; if (mem_ena !== 1'b1) begin failures++; $display("FAIL rst_acc got=%b exp=1", mem_ena); end
    #1 rstn = 1'b0;
    #1;
    checks++; if ({mem_ena, pready, pslverr, mem_wena, prdata, mem_addr, mem_wdata} !== 81'h0) begin
      failures++; $display("FAIL rst_async got=%b%b%b%b/%h/%h/%h exp=0", mem_ena, pready, pslverr, mem_wena, prdata, mem_addr, mem_wdata);
    end
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    xfer(15'h000, 1'b1, 32'h1, 4'hF, e, we, ad, ap, dp, rd, er);
    checks++; if ({e, dp, er} !== 3'b110) begin failures++; $display("FAIL rst_fresh_wr got=%b%b%b exp=110", e, dp, er); end
    xfer(15'h000, 1'b0, 32'h0, 4'hF, e, we, ad, ap, dp, rd, er);
    checks++; if (rd !== 32'h11) begin failures++; $display("FAIL rst_fresh_rd got=%h exp=00000011", rd); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_decode_error();
    test_misaligned();
    test_strobe();
    test_back_to_back();
    test_abandon();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
